// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - multi-cycle word load/store stage with write-back select and stall
module memory_access_stage #(
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_LATENCY = 3
) (
  input  logic        clockPulse,
  input  logic        resetN,
  input  logic        Request_Valid,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] Store_Data,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic        Mem_To_Register,
  output logic        Stall,
  output logic        Result_Valid,
  output logic [31:0] Read_Data,
  output logic [31:0] Write_Back_Data,
  output logic        Misaligned
);

  localparam int       DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;
  localparam logic [3:0] LAT_M1   = 4'(MEM_LATENCY - 1);

  logic [0:0]  r_state;
  logic [3:0]  r_count;
  logic [31:0] r_addr;
  logic [31:0] r_store;
  logic        r_wr;
  logic        r_m2r;
  logic        r_valid;
  logic [31:0] r_read_data;
  logic [31:0] r_wb_data;
  logic        r_misaligned;
  logic [31:0] r_mem [DEPTH];

  logic                  w_mem_op;
  logic                  w_aligned;
  logic                  w_final;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_mem_word;

  assign w_mem_op   = Mem_Read | Mem_Write;
  assign w_aligned  = (ALU_Result[1:0] == 2'b00);
  assign w_final    = (r_state == S_ACCESS) && (r_count == 4'd0);
  // Upper address bits are dropped on purpose so addresses wrap around the array.
  assign w_idx      = r_addr[ADDR_WIDTH+1:2];
  assign w_mem_word = r_mem[w_idx];
  // A store with both flags set is a store; resetN gates the commit so an aborted store never lands.
  assign w_commit   = w_final && r_wr && resetN;

  assign Stall           = (r_state == S_ACCESS);
  assign Result_Valid    = r_valid;
  assign Read_Data       = r_read_data;
  assign Write_Back_Data = r_wb_data;
  assign Misaligned      = r_misaligned;

  // Data array: written only on the last access cycle of a store, never cleared by reset.
  always_ff @(posedge clockPulse) begin
    if (w_commit) begin
      r_mem[w_idx] <= r_store;
    end
  end

  // Request capture, latency countdown and registered result outputs.
  always_ff @(posedge clockPulse or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_count      <= 4'd0;
      r_addr       <= 32'd0;
      r_store      <= 32'd0;
      r_wr         <= 1'b0;
      r_m2r        <= 1'b0;
      r_valid      <= 1'b0;
      r_read_data  <= 32'd0;
      r_wb_data    <= 32'd0;
      r_misaligned <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Request_Valid) begin
            r_addr  <= ALU_Result;
            r_store <= Store_Data;
            r_wr    <= Mem_Write;
            r_m2r   <= Mem_To_Register;
            if (w_mem_op && w_aligned) begin
              r_state <= S_ACCESS;
              r_count <= LAT_M1;
            end else begin
              // Non-memory ops pass through; misaligned memory ops are suppressed with a flag.
              r_valid      <= 1'b1;
              r_read_data  <= 32'd0;
              r_misaligned <= w_mem_op;
              r_wb_data    <= w_mem_op ? 32'd0 : ALU_Result;
            end
          end
        end
        S_ACCESS: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            r_state      <= S_IDLE;
            r_valid      <= 1'b1;
            r_misaligned <= 1'b0;
            if (r_wr) begin
              r_read_data <= 32'd0;
              r_wb_data   <= r_addr;
            end else begin
              r_read_data <= w_mem_word;
              r_wb_data   <= r_m2r ? w_mem_word : r_addr;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - directed and randomized bench for memory_access_stage
module tb_memory_access_stage;

  localparam int AW    = 8;
  localparam int LAT   = 3;
  localparam int DEPTH = 2 ** AW;

  logic        clk = 1'b0;
  logic        resetN;
  logic        Request_Valid;
  logic [31:0] ALU_Result;
  logic [31:0] Store_Data;
  logic        Mem_Read;
  logic        Mem_Write;
  logic        Mem_To_Register;
  logic        Stall;
  logic        Result_Valid;
  logic [31:0] Read_Data;
  logic [31:0] Write_Back_Data;
  logic        Misaligned;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_mem [DEPTH];
  bit          known [DEPTH];

  memory_access_stage #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
    .clockPulse(clk),
    .resetN(resetN),
    .Request_Valid(Request_Valid),
    .ALU_Result(ALU_Result),
    .Store_Data(Store_Data),
    .Mem_Read(Mem_Read),
    .Mem_Write(Mem_Write),
    .Mem_To_Register(Mem_To_Register),
    .Stall(Stall),
    .Result_Valid(Result_Valid),
    .Read_Data(Read_Data),
    .Write_Back_Data(Write_Back_Data),
    .Misaligned(Misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_junk();
    Request_Valid   = 1'($urandom_range(0, 1));
    ALU_Result      = $urandom();
    Store_Data      = $urandom();
    Mem_Read        = 1'($urandom_range(0, 1));
    Mem_Write       = 1'($urandom_range(0, 1));
    Mem_To_Register = 1'($urandom_range(0, 1));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " stall"}, 32'(Stall), 32'd0);
    check({tag, " valid"}, 32'(Result_Valid), 32'd0);
    check({tag, " rdata"}, Read_Data, 32'd0);
    check({tag, " wb"}, Write_Back_Data, 32'd0);
    check({tag, " mis"}, 32'(Misaligned), 32'd0);
  endtask

  // Issue one operation, predict its outcome from the behavioural rules, then check it.
  task automatic do_op(input logic rd, input logic wr, input logic m2r,
                       input logic [31:0] addr, input logic [31:0] data, input string tag);
    int          idx;
    bit          mem_op;
    bit          aligned;
    bit          data_known;
    logic [31:0] e_rd;
    logic [31:0] e_wb;
    logic        e_mis;
    idx        = int'((addr >> 2) % DEPTH);
    mem_op     = rd || wr;
    aligned    = (addr % 4) == 0;
    data_known = 1'b1;
    e_mis      = 1'b0;
    if (mem_op && !aligned) begin
      e_mis = 1'b1;
      e_rd  = 32'd0;
      e_wb  = 32'd0;
    end else if (!mem_op || wr) begin
      e_rd = 32'd0;
      e_wb = addr;
      if (wr) begin
        model_mem[idx] = data;
        known[idx]     = 1'b1;
      end
    end else begin
      data_known = known[idx];
      e_rd       = model_mem[idx];
      e_wb       = m2r ? model_mem[idx] : addr;
    end

    Request_Valid   = 1'b1;
    ALU_Result      = addr;
    Store_Data      = data;
    Mem_Read        = rd;
    Mem_Write       = wr;
    Mem_To_Register = m2r;
    step();
    Request_Valid = 1'b0;

    if (mem_op && aligned) begin
      check({tag, " stall0"}, 32'(Stall), 32'd1);
      check({tag, " early valid"}, 32'(Result_Valid), 32'd0);
      for (int k = 1; k < LAT; k++) begin
        drive_junk();
        step();
        check({tag, " stall"}, 32'(Stall), 32'd1);
        check({tag, " early valid"}, 32'(Result_Valid), 32'd0);
      end
      drive_junk();
      step();
      Request_Valid = 1'b0;
    end

    check({tag, " valid"}, 32'(Result_Valid), 32'd1);
    check({tag, " stall end"}, 32'(Stall), 32'd0);
    check({tag, " mis"}, 32'(Misaligned), 32'(e_mis));
    if (data_known) begin
      check({tag, " rdata"}, Read_Data, e_rd);
      check({tag, " wb"}, Write_Back_Data, e_wb);
    end else if (!m2r) begin
      check({tag, " wb"}, Write_Back_Data, e_wb);
    end
  endtask

  initial begin
    logic [31:0] upper;
    logic [31:0] addr;
    int          sel;
    int          idx;

    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 32'd0;
      known[i]     = 1'b0;
    end
    resetN          = 1'b0;
    Request_Valid   = 1'b0;
    ALU_Result      = 32'd0;
    Store_Data      = 32'd0;
    Mem_Read        = 1'b0;
    Mem_Write       = 1'b0;
    Mem_To_Register = 1'b0;

    step();
    step();
    check_idle_zero("in_reset");
    resetN = 1'b1;
    step();
    check_idle_zero("after_reset");

    do_op(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, "st10");
    do_op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, "ld10");
    do_op(1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, "alu");
    do_op(1'b1, 1'b0, 1'b0, 32'h13, 32'h0, "misld");
    do_op(1'b0, 1'b1, 1'b0, 32'h20, 32'h11112222, "st20");
    do_op(1'b0, 1'b1, 1'b0, 32'h22, 32'h99999999, "misst");
    do_op(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, "ld20");

    do_op(1'b0, 1'b1, 1'b0, 32'h40, 32'h01234567, "st40pre");
    do_op(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, "ld40pre");
    Request_Valid   = 1'b1;
    ALU_Result      = 32'h40;
    Store_Data      = 32'h55;
    Mem_Read        = 1'b0;
    Mem_Write       = 1'b1;
    Mem_To_Register = 1'b0;
    step();
    Request_Valid = 1'b0;
    for (int k = 1; k < LAT; k++) step();
    resetN = 1'b0;
    #1;
    check_idle_zero("abort_reset");
    step();
    check_idle_zero("abort_reset_edge");
    resetN = 1'b1;
    step();
    check({"post_abort", " valid"}, 32'(Result_Valid), 32'd0);
    do_op(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, "ld40post");

    do_op(1'b0, 1'b1, 1'b0, 32'h404, 32'hA5A5A5A5, "st404");
    do_op(1'b1, 1'b0, 1'b1, 32'h004, 32'h0, "ld004wrap");
    do_op(1'b1, 1'b1, 1'b1, 32'h80, 32'hCAFEF00D, "both");
    do_op(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, "ld80");

    for (int n = 0; n < 60; n++) begin
      sel   = $urandom_range(0, 4);
      idx   = $urandom_range(0, 15);
      upper = $urandom() & ~32'h3FF;
      addr  = upper | (32'(idx) << 2);
      case (sel)
        0: do_op(1'b0, 1'b1, 1'b0, addr, $urandom(), "rnd_st");
        1: do_op(1'b1, 1'b0, 1'($urandom_range(0, 1)), addr, $urandom(), "rnd_ld");
        2: do_op(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom(), $urandom(), "rnd_alu");
        3: do_op(1'($urandom_range(0, 1)), 1'b1, 1'b0, addr | 32'($urandom_range(1, 3)),
                 $urandom(), "rnd_mis");
        default: do_op(1'b1, 1'b1, 1'($urandom_range(0, 1)), addr, $urandom(), "rnd_both");
      endcase
    end

    step();
    check({"quiet", " valid"}, 32'(Result_Valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
